// File: rtl/rgb_luma_pkg.sv
// Shared definitions for the RGB-to-luma pipeline: mode encoding, 8-bit reference
// coefficient sets and width helpers for the product and sum datapaths.
package rgb_luma_pkg;

  typedef enum logic [1:0] {
    MODE_BT601 = 2'd0,
    MODE_BT709 = 2'd1,
    MODE_AVG   = 2'd2,
    MODE_PROG  = 2'd3
  } luma_mode_e;

  // Reference coefficients in Q0.8; each set sums to exactly 256 (1.0).
  localparam int unsigned BT601_R = 77;
  localparam int unsigned BT601_G = 150;
  localparam int unsigned BT601_B = 29;
  localparam int unsigned BT709_R = 54;
  localparam int unsigned BT709_G = 183;
  localparam int unsigned BT709_B = 19;
  localparam int unsigned AVG_R   = 85;
  localparam int unsigned AVG_G   = 85;
  localparam int unsigned AVG_B   = 86;

  function automatic int unsigned prod_w(input int unsigned pix_w, input int unsigned coef_w);
    return pix_w + coef_w + 1;
  endfunction

  function automatic int unsigned sum_w(input int unsigned pix_w, input int unsigned coef_w);
    return prod_w(pix_w, coef_w) + 2;
  endfunction

  function automatic int unsigned scale_coef(input int unsigned c8, input int unsigned coef_w);
    if (coef_w >= 8) return c8 << (coef_w - 8);
    else             return c8 >> (8 - coef_w);
  endfunction

endpackage

// File: rtl/luma_pipe_slice.sv
// One elastic pipeline register: holds a beat plus its valid flag and loads
// whenever it is empty or its current beat moves downstream.
module luma_pipe_slice #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         up_valid,
  input  logic [W-1:0] up_data,
  output logic         up_ready,
  output logic         valid,
  output logic [W-1:0] data,
  input  logic         down_ready
);

  assign up_ready = !valid || down_ready;

  // NOTE: non-blocking assignments so every stage samples its neighbour's pre-edge value.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid <= 1'b0;
      // NOTE: the payload is reset too, so outputs read as zero rather than X after reset.
      data  <= '0;
    end else if (up_ready) begin
      valid <= up_valid;
      if (up_valid) data <= up_data;
    end
  end

endmodule

// File: rtl/rgb_to_luma_pipe.sv
// Three-stage pipelined RGB-to-luma converter with valid/ready flow control and frame sideband.
// Define RGB2Y_ROUND_EN to round half up before the shift; otherwise the result is truncated.
module rgb_to_luma_pipe
  import rgb_luma_pkg::*;
#(
  parameter int PIX_W  = 8,
  parameter int COEF_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [PIX_W-1:0]  red_i,
  input  logic [PIX_W-1:0]  green_i,
  input  logic [PIX_W-1:0]  blue_i,
  input  logic              sof_i,
  input  logic              eof_i,
  input  logic [1:0]        mode_i,
  input  logic [COEF_W:0]   coef_r_i,
  input  logic [COEF_W:0]   coef_g_i,
  input  logic [COEF_W:0]   coef_b_i,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [PIX_W-1:0]  luma_o,
  output logic              sof_o,
  output logic              eof_o,
  output logic              frame_done_o
);

  localparam int CW = COEF_W + 1;
  localparam int PW = prod_w(PIX_W, COEF_W);
  localparam int SW = sum_w(PIX_W, COEF_W);

  localparam logic [CW-1:0] C601_R = CW'(scale_coef(BT601_R, COEF_W));
  localparam logic [CW-1:0] C601_G = CW'(scale_coef(BT601_G, COEF_W));
  localparam logic [CW-1:0] C601_B = CW'(scale_coef(BT601_B, COEF_W));
  localparam logic [CW-1:0] C709_R = CW'(scale_coef(BT709_R, COEF_W));
  localparam logic [CW-1:0] C709_G = CW'(scale_coef(BT709_G, COEF_W));
  localparam logic [CW-1:0] C709_B = CW'(scale_coef(BT709_B, COEF_W));
  localparam logic [CW-1:0] CAVG_R = CW'(scale_coef(AVG_R, COEF_W));
  localparam logic [CW-1:0] CAVG_G = CW'(scale_coef(AVG_G, COEF_W));
  localparam logic [CW-1:0] CAVG_B = CW'(scale_coef(AVG_B, COEF_W));

  localparam logic [SW-1:0] PIX_MAX = SW'((1 << PIX_W) - 1);
`ifdef RGB2Y_ROUND_EN
  localparam logic [SW-1:0] ROUND_ADD = SW'(1) << (COEF_W - 1);
`else
  localparam logic [SW-1:0] ROUND_ADD = '0;
`endif

  typedef struct packed {
    logic [PIX_W-1:0] r;
    logic [PIX_W-1:0] g;
    logic [PIX_W-1:0] b;
    logic             sof;
    logic             eof;
    logic [CW-1:0]    cr;
    logic [CW-1:0]    cg;
    logic [CW-1:0]    cb;
  } s1_t;

  typedef struct packed {
    logic [PW-1:0] pr;
    logic [PW-1:0] pg;
    logic [PW-1:0] pb;
    logic          sof;
    logic          eof;
  } s2_t;

  typedef struct packed {
    logic [PIX_W-1:0] luma;
    logic             sof;
    logic             eof;
  } s3_t;

  // Coefficient set latched on each accepted start-of-frame beat.
  luma_mode_e    held_mode;
  logic [CW-1:0] held_r, held_g, held_b;

  always_ff @(posedge clk) begin
    if (rst) begin
      held_mode <= MODE_BT601;
      held_r    <= '0;
      held_g    <= '0;
      held_b    <= '0;
    end else if (in_valid && in_ready && sof_i) begin
      held_mode <= luma_mode_e'(mode_i);
      held_r    <= coef_r_i;
      held_g    <= coef_g_i;
      held_b    <= coef_b_i;
    end
  end

  // The sof beat itself already uses the new settings; if it is not accepted
  // this cycle, stage 1 does not load, so the selection is harmless.
  luma_mode_e    cur_mode;
  logic [CW-1:0] sel_r, sel_g, sel_b;
  s1_t           s1_in, s1_q;

  always_comb begin
    // NOTE: every output gets a default first so no path through the case infers a latch.
    cur_mode = sof_i ? luma_mode_e'(mode_i) : held_mode;
    sel_r    = C601_R;
    sel_g    = C601_G;
    sel_b    = C601_B;
    case (cur_mode)
      MODE_BT601: begin sel_r = C601_R; sel_g = C601_G; sel_b = C601_B; end
      MODE_BT709: begin sel_r = C709_R; sel_g = C709_G; sel_b = C709_B; end
      MODE_AVG:   begin sel_r = CAVG_R; sel_g = CAVG_G; sel_b = CAVG_B; end
      MODE_PROG: begin
        sel_r = sof_i ? coef_r_i : held_r;
        sel_g = sof_i ? coef_g_i : held_g;
        sel_b = sof_i ? coef_b_i : held_b;
      end
      default: ;
    endcase
    s1_in = '{r: red_i, g: green_i, b: blue_i, sof: sof_i, eof: eof_i,
              cr: sel_r, cg: sel_g, cb: sel_b};
  end

  logic s1_valid, s2_valid, s2_ready, s3_ready;
  s2_t  s2_in, s2_q;
  s3_t  s3_in, s3_q;

  luma_pipe_slice #(.W($bits(s1_t))) u_s1 (
    .clk        (clk),
    .rst        (rst),
    .up_valid   (in_valid),
    .up_data    (s1_in),
    .up_ready   (in_ready),
    .valid      (s1_valid),
    .data       (s1_q),
    .down_ready (s2_ready)
  );

  always_comb begin
    s2_in.pr  = PW'(s1_q.r) * PW'(s1_q.cr);
    s2_in.pg  = PW'(s1_q.g) * PW'(s1_q.cg);
    s2_in.pb  = PW'(s1_q.b) * PW'(s1_q.cb);
    s2_in.sof = s1_q.sof;
    s2_in.eof = s1_q.eof;
  end

  luma_pipe_slice #(.W($bits(s2_t))) u_s2 (
    .clk        (clk),
    .rst        (rst),
    .up_valid   (s1_valid),
    .up_data    (s2_in),
    .up_ready   (s2_ready),
    .valid      (s2_valid),
    .data       (s2_q),
    .down_ready (s3_ready)
  );

  logic [SW-1:0] sum, shifted;

  always_comb begin
    sum       = SW'(s2_q.pr) + SW'(s2_q.pg) + SW'(s2_q.pb) + ROUND_ADD;
    shifted   = sum >> COEF_W;
    s3_in.sof = s2_q.sof;
    s3_in.eof = s2_q.eof;
    if (shifted > PIX_MAX) s3_in.luma = '1;
    else                   s3_in.luma = shifted[PIX_W-1:0];
  end

  luma_pipe_slice #(.W($bits(s3_t))) u_s3 (
    .clk        (clk),
    .rst        (rst),
    .up_valid   (s2_valid),
    .up_data    (s3_in),
    .up_ready   (s3_ready),
    .valid      (out_valid),
    .data       (s3_q),
    .down_ready (out_ready)
  );

  assign luma_o       = s3_q.luma;
  assign sof_o        = s3_q.sof;
  assign eof_o        = s3_q.eof;
  assign frame_done_o = out_valid && out_ready && s3_q.eof;

endmodule
